// File: rtl/axi_sram_slave.sv
// AXI4 slave in front of a single-port 2**MEM_AW x 32-bit SRAM; one transaction at a time.
// Define AXI_SLV_BURST_EN to honour len/burst; otherwise every transfer is a single beat.
module axi_sram_slave #(
  parameter int unsigned MEM_AW = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  i_arid,
  input  logic [31:0] i_araddr,
  input  logic [7:0]  i_arlen,
  input  logic [2:0]  i_arsize,
  input  logic [1:0]  i_arburst,
  input  logic        i_arvalid,
  input  logic [1:0]  i_arlock,
  input  logic [3:0]  i_arcache,
  input  logic [2:0]  i_arprot,
  output logic        o_arready,
  output logic [3:0]  o_rid,
  output logic [31:0] o_rdata,
  output logic [1:0]  o_rresp,
  output logic        o_rlast,
  output logic        o_rvalid,
  input  logic        i_rready,
  input  logic [3:0]  i_awid,
  input  logic [31:0] i_awaddr,
  input  logic [7:0]  i_awlen,
  input  logic [2:0]  i_awsize,
  input  logic [1:0]  i_awburst,
  input  logic        i_awvalid,
  input  logic [1:0]  i_awlock,
  input  logic [3:0]  i_awcache,
  input  logic [2:0]  i_awprot,
  output logic        o_awready,
  input  logic [3:0]  i_wid,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  input  logic        i_wlast,
  input  logic        i_wvalid,
  output logic        o_wready,
  output logic [3:0]  o_bid,
  output logic [1:0]  o_bresp,
  output logic        o_bvalid,
  input  logic        i_bready
);

  typedef enum logic [2:0] {StIdle, StRdMem, StRdData, StWrData, StWrResp} state_e;

  state_e            r_state;
  logic              r_last_rd;  // 1 when the previous grant went to the read channel
  logic [3:0]        r_id;
  logic [MEM_AW-1:0] r_addr;
  logic [7:0]        r_len;
  logic [7:0]        r_beat;
  logic [1:0]        r_burst;
  logic              r_err;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [2**MEM_AW];

  logic              w_grant_rd;
  logic              w_ar_hs;
  logic              w_aw_hs;
  logic              w_last_beat;
  logic [7:0]        w_arlen;
  logic [7:0]        w_awlen;
  logic [1:0]        w_arburst;
  logic [1:0]        w_awburst;
  logic [MEM_AW-1:0] w_next_addr;
  logic              w_unused;

`ifdef AXI_SLV_BURST_EN
  assign w_arlen   = i_arlen;
  assign w_awlen   = i_awlen;
  assign w_arburst = i_arburst;
  assign w_awburst = i_awburst;
  assign w_unused  = ^{i_araddr[31:MEM_AW+2], i_araddr[1:0], i_awaddr[31:MEM_AW+2],
                       i_awaddr[1:0], i_arsize, i_awsize, i_arlock, i_arcache, i_arprot,
                       i_awlock, i_awcache, i_awprot, i_wid};
`else
  assign w_arlen   = 8'd0;
  assign w_awlen   = 8'd0;
  assign w_arburst = 2'b00;
  assign w_awburst = 2'b00;
  assign w_unused  = ^{i_araddr[31:MEM_AW+2], i_araddr[1:0], i_awaddr[31:MEM_AW+2],
                       i_awaddr[1:0], i_arsize, i_awsize, i_arlock, i_arcache, i_arprot,
                       i_awlock, i_awcache, i_awprot, i_wid, i_arlen, i_awlen, i_arburst,
                       i_awburst};
`endif

  assign w_grant_rd  = i_arvalid & (~i_awvalid | ~r_last_rd);
  assign o_arready   = ~rst & (r_state == StIdle) & i_arvalid & w_grant_rd;
  assign o_awready   = ~rst & (r_state == StIdle) & i_awvalid & ~w_grant_rd;
  assign w_ar_hs     = o_arready;
  assign w_aw_hs     = o_awready;
  assign w_last_beat = (r_beat == r_len);
  // FIXED holds the address; every other burst type steps one word and wraps at the depth.
  assign w_next_addr = (r_burst == 2'b00) ? r_addr
                                          : r_addr + {{(MEM_AW-1){1'b0}}, 1'b1};

  assign o_wready = (r_state == StWrData);
  assign o_rvalid = (r_state == StRdData);
  assign o_bvalid = (r_state == StWrResp);
  assign o_rlast  = o_rvalid & w_last_beat;
  assign o_rdata  = r_rdata;
  assign o_rid    = r_id;
  assign o_bid    = r_id;
  assign o_rresp  = 2'b00;
  assign o_bresp  = r_err ? 2'b10 : 2'b00;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= StIdle;
      r_last_rd <= 1'b0;
      r_id      <= '0;
      r_addr    <= '0;
      r_len     <= '0;
      r_beat    <= '0;
      r_burst   <= '0;
      r_err     <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_ar_hs) begin
            r_id      <= i_arid;
            r_addr    <= i_araddr[MEM_AW+1:2];
            r_len     <= w_arlen;
            r_burst   <= w_arburst;
            r_beat    <= '0;
            r_last_rd <= 1'b1;
            r_state   <= StRdMem;
          end else if (w_aw_hs) begin
            r_id      <= i_awid;
            r_addr    <= i_awaddr[MEM_AW+1:2];
            r_len     <= w_awlen;
            r_burst   <= w_awburst;
            r_beat    <= '0;
            r_err     <= 1'b0;
            r_last_rd <= 1'b0;
            r_state   <= StWrData;
          end
        end
        StRdMem: r_state <= StRdData;
        StRdData: begin
          if (i_rready) begin
            if (w_last_beat) begin
              r_state <= StIdle;
            end else begin
              r_addr  <= w_next_addr;
              r_beat  <= r_beat + 8'd1;
              r_state <= StRdMem;
            end
          end
        end
        StWrData: begin
          if (i_wvalid) begin
            if (i_wlast != w_last_beat) r_err <= 1'b1;
            if (w_last_beat) begin
              r_state <= StWrResp;
            end else begin
              r_addr <= w_next_addr;
              r_beat <= r_beat + 8'd1;
            end
          end
        end
        StWrResp: if (i_bready) r_state <= StIdle;
        default:  r_state <= StIdle;
      endcase
    end
  end

  // Memory array carries no reset so committed beats survive an aborted burst.
  always_ff @(posedge clk) begin
    if (r_state == StRdMem) r_rdata <= r_mem[r_addr];
    if ((r_state == StWrData) && i_wvalid) begin
      for (int i = 0; i < 4; i++) begin
        if (i_wstrb[i]) r_mem[r_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_sram_slave.sv
// Self-checking bench for axi_sram_slave: table-driven write/readback vectors with a
// scoreboard, plus hand-written arbitration, stall, wlast-error and reset sequences.
module tb_axi_sram_slave;
  localparam int unsigned MEM_AW = 12;
`ifdef AXI_SLV_BURST_EN
  localparam bit BURST = 1'b1;
`else
  localparam bit BURST = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;
  logic [3:0]  arid, awid, wid, rid, bid;
  logic [31:0] araddr, awaddr, wdata, rdata;
  logic [7:0]  arlen, awlen;
  logic [2:0]  arsize, awsize, arprot, awprot;
  logic [1:0]  arburst, awburst, arlock, awlock, rresp, bresp;
  logic [3:0]  arcache, awcache, wstrb;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  always #5 clk = ~clk;

  axi_sram_slave #(.MEM_AW(MEM_AW)) u_dut (
    .clk(clk), .rst(rst),
    .i_arid(arid), .i_araddr(araddr), .i_arlen(arlen), .i_arsize(arsize),
    .i_arburst(arburst), .i_arvalid(arvalid), .i_arlock(arlock), .i_arcache(arcache),
    .i_arprot(arprot), .o_arready(arready),
    .o_rid(rid), .o_rdata(rdata), .o_rresp(rresp), .o_rlast(rlast), .o_rvalid(rvalid),
    .i_rready(rready),
    .i_awid(awid), .i_awaddr(awaddr), .i_awlen(awlen), .i_awsize(awsize),
    .i_awburst(awburst), .i_awvalid(awvalid), .i_awlock(awlock), .i_awcache(awcache),
    .i_awprot(awprot), .o_awready(awready),
    .i_wid(wid), .i_wdata(wdata), .i_wstrb(wstrb), .i_wlast(wlast), .i_wvalid(wvalid),
    .o_wready(wready),
    .o_bid(bid), .o_bresp(bresp), .o_bvalid(bvalid), .i_bready(bready)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  id;
    logic        last;
  } rexp_t;

  typedef struct {
    logic [3:0] id;
    logic [1:0] resp;
  } bexp_t;

  typedef struct {
    string       name;
    logic [3:0]  wid;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [3:0]  rid;
    logic [31:0] raddr;
    logic [31:0] exp;
  } vec_t;

  rexp_t       rq[$];
  bexp_t       bq[$];
  logic [31:0] model [int];
  int          n_checks = 0;
  int          n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, input logic [31:0] data, input logic [3:0] strb,
                    input bit bad_last);
    int nb, t, w;
    logic [31:0] d;
    bexp_t e;
    nb = BURST ? int'(len) + 1 : 1;
    w  = int'(addr[13:2]);
    e.id = id;
    e.resp = bad_last ? 2'b10 : 2'b00;
    bq.push_back(e);
    @(negedge clk);
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    t = 0;
    #1;
    while (!awready && t < 20) begin @(negedge clk); #1; t++; end
    chk("aw_handshake", awready, 1);
    @(negedge clk);
    awvalid = 1'b0;
    for (int i = 0; i < nb; i++) begin
      d = data + 32'(i);
      wid = id; wdata = d; wstrb = strb; wlast = (i == nb - 1) ^ bad_last; wvalid = 1'b1;
      #1;
      chk("wready", wready, 1);
      for (int b = 0; b < 4; b++) if (strb[b]) model[w][8*b +: 8] = d[8*b +: 8];
      if (!BURST || burst != 2'b00) w = (w + 1) % 4096;
      @(negedge clk);
    end
    wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
    t = 0;
    #1;
    while (!bvalid && t < 20) begin @(negedge clk); #1; t++; end
    chk("bvalid", bvalid, 1);
    e = bq.pop_front();
    chk("bid", bid, e.id);
    chk("bresp", bresp, e.resp);
    @(negedge clk);
    bready = 1'b0;
  endtask

  task automatic rd(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                    input logic [1:0] burst, output logic [31:0] first);
    int nb, t, w;
    rexp_t e;
    nb = BURST ? int'(len) + 1 : 1;
    w  = int'(addr[13:2]);
    first = 'x;
    for (int i = 0; i < nb; i++) begin
      e.data = model[w]; e.id = id; e.last = (i == nb - 1);
      rq.push_back(e);
      if (!BURST || burst != 2'b00) w = (w + 1) % 4096;
    end
    @(negedge clk);
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1; rready = 1'b1;
    t = 0;
    #1;
    while (!arready && t < 20) begin @(negedge clk); #1; t++; end
    chk("ar_handshake", arready, 1);
    for (int i = 0; i < nb; i++) begin
      t = 0;
      do begin @(negedge clk); arvalid = 1'b0; #1; t++; end while (!rvalid && t < 20);
      chk("r_spacing", t, 2);
      e = rq.pop_front();
      chk("rdata", rdata, e.data);
      chk("rid", rid, e.id);
      chk("rlast", rlast, e.last);
      chk("rresp", rresp, 0);
      if (i == 0) first = rdata;
    end
    @(negedge clk);
    #1;
    chk("r_done", rvalid, 0);
    rready = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t        vecs[6];
    logic [31:0] got, code, snap_d;
    logic [4:0]  snap_c;
    int          ng;

    vecs[0] = '{"full_word",   4'd3, 32'h10,   32'hDEADBEEF, 4'hF,    4'd5, 32'h10,   32'hDEADBEEF};
    vecs[1] = '{"byte_strobe", 4'd3, 32'h10,   32'h11223344, 4'b0101, 4'd5, 32'h10,   32'hDE22BE44};
    vecs[2] = '{"high_alias",  4'd7, 32'h4020, 32'hCAFEF00D, 4'hF,    4'd1, 32'h20,   32'hCAFEF00D};
    vecs[3] = '{"low_bits",    4'd1, 32'h22,   32'hAABBCCDD, 4'b1000, 4'd2, 32'h20,   32'hAAFEF00D};
    vecs[4] = '{"top_word",    4'hF, 32'h3FFC, 32'h12345678, 4'hF,    4'hE, 32'h7FFC, 32'h12345678};
    vecs[5] = '{"no_strobe",   4'd2, 32'h10,   32'hFFFFFFFF, 4'h0,    4'd4, 32'h10,   32'hDE22BE44};

    rst = 1'b1;
    {arid, araddr, arlen, arsize, arburst, arvalid, arlock, arcache, arprot} = '0;
    {awid, awaddr, awlen, awsize, awburst, awvalid, awlock, awcache, awprot} = '0;
    {wid, wdata, wstrb, wlast, wvalid, rready, bready} = '0;
    repeat (3) @(negedge clk);
    arvalid = 1'b1; awvalid = 1'b1;
    #1;
    chk("rst_arready", arready, 0);
    chk("rst_awready", awready, 0);
    chk("rst_wready", wready, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rlast", rlast, 0);
    chk("rst_ids", {rid, bid}, 0);
    chk("rst_resps", {rresp, bresp}, 0);
    arvalid = 1'b0; awvalid = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Both address channels held from reset: grants must go R, W, R, W.
    @(negedge clk);
    araddr = 32'h200; arid = 4'd1; arlen = 8'd0; arburst = 2'b01;
    awaddr = 32'h204; awid = 4'd2; awlen = 8'd0; awburst = 2'b01;
    wdata = 32'h0BADF00D; wstrb = 4'hF; wlast = 1'b1; wvalid = 1'b1;
    rready = 1'b1; bready = 1'b1; arvalid = 1'b1; awvalid = 1'b1;
    code = '0; ng = 0;
    for (int c = 0; c < 14; c++) begin
      #1;
      if (arready && awready) chk("both_ready", 1, 0);
      if (arready && ng < 4) begin code = {code[23:0], 8'h52}; ng++; end
      if (awready && ng < 4) begin code = {code[23:0], 8'h57}; ng++; end
      @(negedge clk);
    end
    arvalid = 1'b0; awvalid = 1'b0; wvalid = 1'b0; wlast = 1'b0;
    model[129] = 32'h0BADF00D;
    chk("grant_order", code, 32'h52575257);
    repeat (4) @(negedge clk);
    rready = 1'b0; bready = 1'b0;

    for (int i = 0; i < 6; i++) begin
      wr(vecs[i].wid, vecs[i].waddr, 8'd0, 2'b01, vecs[i].wdata, vecs[i].wstrb, 1'b0);
      rd(vecs[i].rid, vecs[i].raddr, 8'd0, 2'b01, got);
      chk(vecs[i].name, got, vecs[i].exp);
    end

    // wlast on the wrong beat gives SLVERR; the next clean write clears it.
    wr(4'd4, 32'h50, 8'd0, 2'b01, 32'h55, 4'hF, 1'b1);
    wr(4'd4, 32'h54, 8'd0, 2'b01, 32'h66, 4'hF, 1'b0);

    // len=3 INCR at the top word: wraps to word 0 with bursts, single beat without.
    wr(4'd0, 32'h0, 8'd0, 2'b01, 32'h77777777, 4'hF, 1'b0);
    wr(4'd9, 32'h3FFC, 8'd3, 2'b01, 32'hA0A0A000, 4'hF, 1'b0);
    rd(4'd6, 32'h3FFC, 8'd3, 2'b01, got);
    rd(4'd6, 32'h0, 8'd0, 2'b01, got);
    wr(4'd2, 32'h80, 8'd1, 2'b00, 32'h100, 4'hF, 1'b0);
    rd(4'd3, 32'h80, 8'd0, 2'b01, got);

    // rready stalled for 5 cycles: read beat held, awready stays low.
    @(negedge clk);
    arid = 4'd8; araddr = 32'h10; arlen = 8'd0; arvalid = 1'b1; rready = 1'b0;
    #1;
    chk("stall_ar", arready, 1);
    @(negedge clk);
    arvalid = 1'b0; awvalid = 1'b1; awaddr = 32'h300; awid = 4'd1;
    @(negedge clk);
    #1;
    chk("stall_rvalid", rvalid, 1);
    chk("stall_rdata", rdata, model[4]);
    snap_d = rdata; snap_c = {rid, rlast};
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      #1;
      chk("stall_hold", {rvalid, !awready, rdata == snap_d, {rid, rlast} == snap_c}, 4'hF);
    end
    awvalid = 1'b0; rready = 1'b1;
    @(negedge clk);
    #1;
    chk("stall_release", rvalid, 0);
    rready = 1'b0;

    // Reset in the middle of a read beat aborts it at once.
    @(negedge clk);
    arid = 4'd9; araddr = 32'h10; arvalid = 1'b1;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    #1;
    chk("pre_rst_rvalid", rvalid, 1);
    rst = 1'b1;
    #1;
    chk("abort_rvalid", rvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    rd(4'hA, 32'h10, 8'd0, 2'b01, got);
    chk("after_rst_read", got, 32'hDE22BE44);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
AXI_SRAM_SLAVE -- requirements
Module: axi_sram_slave

Interface
REQ-001 Parameter MEM_AW, default 10, SHALL set the word-address width; memory depth SHALL be 2**MEM_AW 32-bit words.
REQ-002 clk  in  1  sole clock; all state SHALL update on the rising edge.
REQ-003 rst  in  1  reset, asynchronous and active-high.
REQ-004 arid/araddr/arlen/arsize/arburst/arvalid  in  4/32/8/3/2/1  AXI read address; arready  out  1.
REQ-005 rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1  AXI read data; rready  in  1.
REQ-006 awid/awaddr/awlen/awsize/awburst/awvalid  in  4/32/8/3/2/1  AXI write address; awready  out  1.
REQ-007 wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1  AXI write data; wready  out  1.
REQ-008 bid/bresp/bvalid  out  4/2/1  AXI write response; bready  in  1.
REQ-009 arlock/arcache/arprot/awlock/awcache/awprot  in  2/4/3  accepted and ignored.

Function
REQ-010 Control FSM SHALL have states IDLE, RD_MEM, RD_DATA, WR_DATA, WR_RESP; memory is single-port, so exactly one transaction SHALL be active at a time.
REQ-011 In IDLE, arready SHALL equal arvalid & grant_rd and awready SHALL equal awvalid & ~grant_rd; both SHALL be 0 in every other state.
REQ-012 grant_rd SHALL be 1 when only arvalid is high, 0 when only awvalid is high; when both are high it SHALL favour the channel not granted last (1-bit last_grant register, reset to write so read wins first).
REQ-013 AR handshake SHALL latch id, addr[MEM_AW+1:2], len, burst, clear beat counter, go to RD_MEM.
REQ-014 RD_MEM SHALL issue a synchronous memory read and go to RD_DATA; RD_DATA SHALL drive rvalid=1, rdata, rid=latched id, rresp=2'b00, rlast=(beat==len).
REQ-015 rvalid/rdata/rid/rlast SHALL hold stable until rvalid&rready; then last beat -> IDLE, else advance address, beat+1, -> RD_MEM.
REQ-016 Latency from AR handshake cycle to first rvalid SHALL be 2 cycles; beat-to-beat spacing with rready=1 SHALL be 2 cycles.
REQ-017 AW handshake SHALL latch id, addr, len, burst, clear beat counter, go to WR_DATA; W is not accepted before its AW (wready=0 outside WR_DATA).
REQ-018 In WR_DATA wready SHALL be 1; on wvalid&wready, bytes with wstrb[i]=1 SHALL be written to wdata[8i+7:8i] at the current address in that cycle; bytes with wstrb[i]=0 SHALL be unchanged.
REQ-019 Write termination SHALL use the internal beat counter (beat==len), not wlast; then -> WR_RESP.
REQ-020 A sticky error flag SHALL be set if any beat has wlast != (beat==len); bresp SHALL be 2'b10 (SLVERR) if set, else 2'b00.
REQ-021 WR_RESP SHALL drive bvalid=1, bid=latched id, holding until bready; then -> IDLE.
REQ-022 Address bits above MEM_AW+1 SHALL be ignored (aliasing); addr[1:0] and arsize/awsize SHALL be ignored; the word address SHALL wrap modulo depth on increment.
REQ-023 A read-after-write to the same word SHALL return the new data (write completes before the read is granted).

Reset
REQ-024 On rst: state=IDLE, last_grant=write, counters and error flag cleared; arready, awready, wready, rvalid, bvalid, rlast SHALL be 0; rid, bid, rresp, bresp SHALL be 0; memory contents SHALL NOT be reset.
REQ-025 rst asserted mid-transaction SHALL abort it immediately; partial write beats already committed SHALL remain in memory.

Configuration
REQ-026 Macro AXI_SLV_BURST_EN defined: len honoured (1..256 beats); burst 2'b00 (FIXED) keeps the address, 2'b01/2'b10/2'b11 increment by one word per beat.
REQ-027 Macro AXI_SLV_BURST_EN undefined: len and burst SHALL be treated as 0; every read is one beat with rlast=1; every write ends after one beat; REQ-020 still compares wlast against 1.

Verification
REQ-028 Write awaddr=0x10, wdata=0xDEADBEEF, wstrb=4'hF, id=3 -> bvalid with bid=3, bresp=0; read araddr=0x10, arid=5 -> rdata=0xDEADBEEF, rid=5, rlast=1, rvalid 2 cycles after AR handshake.
REQ-029 Then write 0x10, wdata=0x11223344, wstrb=4'b0101 -> readback 0xDE22BE44.
REQ-030 arvalid and awvalid asserted together from reset, held -> read granted first, write next; repeated -> grants alternate.
REQ-031 rready held 0 for 5 cycles in RD_DATA -> rvalid, rdata, rid, rlast stable; awready stays 0 throughout.
REQ-032 Write len=0 with wlast=0 -> bresp=2'b10; with AXI_SLV_BURST_EN, INCR len=3 write at 0x3FFC (MEM_AW=12) -> beats wrap to words 0xFFF,0x000,0x001,0x002 and read burst returns them with rlast only on beat 4.
REQ-033 rst pulsed during RD_DATA -> rvalid=0 immediately, next arvalid accepted normally.
